alu_sequential_exec: RTL and testbench
======================================

Name: alu_sequential_exec

Overview:
- Execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code and the register/immediate operands, and produces the ALU result, a zero flag and an invalid-operation flag.
- ADD, OR and LUI complete in one cycle.
- SLL and SRL run on an iterative 1-bit-per-cycle shifter, so the block uses a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and at least 32.
- SHAMT_WIDTH, 5, shift-amount width; max shift is 2^SHAMT_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted on a rising edge only when busy_o=0.
- alu_operation_i  input  4  0000 LUI, 0001 OR, 0010 SLL, 0011 ADD, 0100 SRL; all other codes are invalid (1001 is the decoder default).
- a_i  input  DATA_WIDTH  operand A (rs).
- b_i  input  DATA_WIDTH  operand B (rt or immediate); this is the shifted operand for SLL/SRL.
- shamt_i  input  SHAMT_WIDTH  shift amount.
- busy_o  input-blocking status, output  1  high while in SHIFT.
- done_o  output  1  one-cycle pulse; result is valid.
- alu_data_o  output  DATA_WIDTH  registered result, held until the next accept.
- zero_o  output  1  registered; equals (alu_data_o==0).
- invalid_op_o  output  1  registered; 1 when the last accepted code was unsupported.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - busy_o=0, done_o=0, alu_data_o=0, zero_o=1, invalid_op_o=0.
  - Internal shift counter and shift register cleared.
  - Reset mid-shift aborts the operation: no done_o pulse is produced and no partial result appears.
- States: IDLE, SHIFT, DONE.
- Accept: start_i=1 on an edge while in IDLE or DONE. All inputs are captured on that edge; later input changes have no effect.
- Non-shift ops, or SLL/SRL with shamt_i=0:
  - Result registered on the accept edge; state goes to DONE.
  - done_o is high in the cycle after the accept edge (latency 1).
- SLL/SRL with shamt_i=n>0:
  - Accept edge loads b_i into the shift register and n into the counter; state goes to SHIFT.
  - Each following edge shifts by 1 (SLL left, SRL logical right, zero fill) and decrements the counter.
  - The edge that performs the nth shift writes alu_data_o and moves to DONE.
  - done_o is visible n cycles after the accept edge.
  - busy_o=1 for exactly n cycles.
- Arithmetic:
  - ADD = a_i+b_i modulo 2^DATA_WIDTH; no overflow flag, no exception.
  - OR = a_i|b_i.
  - LUI = {b_i[15:0], zeros} placed in the upper half; a_i is ignored.
- Invalid code: alu_data_o=0, zero_o=1, invalid_op_o=1, latency 1.
- Flags: invalid_op_o and zero_o update only when alu_data_o updates.
- DONE state:
  - done_o=1 for exactly one cycle.
  - Next state is IDLE, or a new accept if start_i=1. Back-to-back operations are allowed with no bubble, so done_o may be high on consecutive cycles.
- start_i while busy_o=1 is ignored and not queued; the current operation completes unaffected.
- alu_data_o, zero_o and invalid_op_o are stable outside the update edges. During SHIFT, alu_data_o keeps the previous result; intermediate shift values are not visible.
- The counter never underflows. Shift amounts at or above DATA_WIDTH cannot occur with the default parameters; if DATA_WIDTH < 2^SHAMT_WIDTH, such a shift yields 0.

Test Plan:
- ADD wrap and OR:
  - ADD, a=0xFFFFFFFF, b=0x00000002, start 1 cycle -> done_o after 1 cycle, alu_data_o=0x00000001, zero_o=0.
  - Then OR, a=0x0F0F0000, b=0x0000F0F0 back-to-back -> next cycle done_o=1 again, alu_data_o=0x0F0FF0F0.
- LUI: b=0x1234ABCD -> 0xABCD0000 after 1 cycle, busy_o never high.
- SLL and SRL:
  - SLL, b=0x00000001, shamt=31 -> busy_o high 31 cycles, done_o after 31 cycles, result 0x80000000.
  - SRL, b=0x80000000, shamt=4 -> 0x08000000 after 4 cycles.
  - SLL with shamt=0, b=0x5 -> result 0x5 at latency 1.
- Ignored start: during an SLL shamt=8 run, pulse start_i with ADD operands at cycle 3 -> ignored; a single done_o after 8 cycles with the SLL result; alu_data_o unchanged until then.
- Invalid code: code 1001 with a=b=0xFFFF -> alu_data_o=0, zero_o=1, invalid_op_o=1.
  - A following valid ADD clears invalid_op_o.
- Reset mid-shift: SRL shamt=20, assert reset at cycle 7 asynchronously (mid-cycle) -> all outputs immediately at reset values; no done_o pulse after release; a new ADD works normally.

Source files
------------

// File: rtl/alu_sequential_exec.sv
// Execute stage behind the ALU control decoder: single-cycle ADD/OR/LUI and
// iterative 1-bit-per-cycle SLL/SRL with a start/busy/done handshake.
module alu_sequential_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  alu_data_o,
  output logic                   zero_o,
  output logic                   invalid_op_o
);

  localparam logic [3:0] OP_LUI = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_zero;
  logic                   r_invalid;
  logic [DATA_WIDTH-1:0]  r_shreg;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic                   r_left;

  logic                   w_is_shift;
  logic                   w_invalid;
  logic [DATA_WIDTH-1:0]  w_result;
  logic [DATA_WIDTH-1:0]  w_sh_next;

  assign w_is_shift = (alu_operation_i == OP_SLL) || (alu_operation_i == OP_SRL);
  assign w_sh_next  = r_left ? (r_shreg << 1) : (r_shreg >> 1);

  // Single-cycle result; a zero shift amount simply passes b through.
  always_comb begin
    w_result  = '0;
    w_invalid = 1'b0;
    case (alu_operation_i)
      OP_LUI:         w_result = {b_i[15:0], {(DATA_WIDTH-16){1'b0}}};
      OP_OR:          w_result = a_i | b_i;
      OP_ADD:         w_result = a_i + b_i;
      OP_SLL, OP_SRL: w_result = b_i;
      default:        w_invalid = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= '0;
      r_zero    <= 1'b1;
      r_invalid <= 1'b0;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_left    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            if (w_is_shift && (shamt_i != '0)) begin
              r_shreg <= b_i;
              r_cnt   <= shamt_i;
              r_left  <= (alu_operation_i == OP_SLL);
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              r_data    <= w_result;
              r_zero    <= (w_result == '0);
              r_invalid <= w_invalid;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          // start_i is deliberately not looked at here: requests while busy are dropped.
          r_shreg <= w_sh_next;
          r_cnt   <= r_cnt - SHAMT_WIDTH'(1);
          if (r_cnt == SHAMT_WIDTH'(1)) begin
            r_data    <= w_sh_next;
            r_zero    <= (w_sh_next == '0);
            r_invalid <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign alu_data_o   = r_data;
  assign zero_o       = r_zero;
  assign invalid_op_o = r_invalid;

endmodule

// File: tb/tb_alu_sequential_exec.sv
// Directed bench for alu_sequential_exec: vector table for single-cycle ops,
// hand-written sequences for shifts, ignored start and mid-shift reset.
module tb_alu_sequential_exec;

  localparam logic [3:0] OP_LUI = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_BAD = 4'b1001;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic        exp_inv;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  shamt_i;
  logic        busy_o, done_o, zero_o, invalid_op_o;
  logic [31:0] alu_data_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_data;
  vec_t        vecs [13];

  alu_sequential_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .alu_operation_i(alu_operation_i),
    .a_i(a_i), .b_i(b_i), .shamt_i(shamt_i), .busy_o(busy_o), .done_o(done_o),
    .alu_data_o(alu_data_o), .zero_o(zero_o), .invalid_op_o(invalid_op_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
    alu_operation_i = op;
    a_i = a;
    b_i = b;
    shamt_i = sh;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    set_in(v.op, v.a, v.b, v.shamt);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk1({name, "_done"}, done_o, 1'b1);
    chk1({name, "_busy"}, busy_o, 1'b0);
    chk32({name, "_data"}, alu_data_o, v.exp_data);
    chk1({name, "_zero"}, zero_o, v.exp_zero);
    chk1({name, "_inv"}, invalid_op_o, v.exp_inv);
    last_data = v.exp_data;
  endtask

  // inject >= 0 pulses an ADD request during that busy cycle.
  task automatic run_shift(input string name, input logic [3:0] op, input logic [31:0] b,
                           input logic [4:0] n, input logic [31:0] exp, input int inject);
    int cnt = 0;
    set_in(op, 32'h0, b, n);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    set_in(OP_ADD, 32'h1, 32'h1, 5'd0);
    while (busy_o === 1'b1 && cnt < 200) begin
      chk1({name, "_done_low"}, done_o, 1'b0);
      chk32({name, "_hold"}, alu_data_o, last_data);
      start_i = (cnt == inject);
      cnt++;
      tick();
    end
    start_i = 1'b0;
    chk32({name, "_busy_cycles"}, 32'(cnt), 32'(n));
    chk1({name, "_done"}, done_o, 1'b1);
    chk32({name, "_data"}, alu_data_o, exp);
    chk1({name, "_zero"}, zero_o, exp == 32'h0);
    chk1({name, "_inv"}, invalid_op_o, 1'b0);
    last_data = exp;
    tick();
    chk1({name, "_single_done"}, done_o, 1'b0);
    chk1({name, "_busy_after"}, busy_o, 1'b0);
    chk32({name, "_data_after"}, alu_data_o, exp);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    vecs[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000002, 5'd0, 32'h00000001, 1'b0, 1'b0};
    vecs[1]  = '{OP_OR,  32'h0F0F0000, 32'h0000F0F0, 5'd0, 32'h0F0FF0F0, 1'b0, 1'b0};
    vecs[2]  = '{OP_LUI, 32'hDEADBEEF, 32'h1234ABCD, 5'd0, 32'hABCD0000, 1'b0, 1'b0};
    vecs[3]  = '{OP_SLL, 32'h0,        32'h00000005, 5'd0, 32'h00000005, 1'b0, 1'b0};
    vecs[4]  = '{OP_SRL, 32'h0,        32'h00000008, 5'd0, 32'h00000008, 1'b0, 1'b0};
    vecs[5]  = '{OP_ADD, 32'h00000000, 32'h00000000, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[6]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[7]  = '{OP_BAD, 32'h0000FFFF, 32'h0000FFFF, 5'd0, 32'h00000000, 1'b1, 1'b1};
    vecs[8]  = '{OP_ADD, 32'h00000001, 32'h00000002, 5'd0, 32'h00000003, 1'b0, 1'b0};
    vecs[9]  = '{4'b0101, 32'h00000001, 32'h00000002, 5'd3, 32'h00000000, 1'b1, 1'b1};
    vecs[10] = '{OP_OR,  32'h00000000, 32'h00000000, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{OP_LUI, 32'hFFFFFFFF, 32'hFFFF0000, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b0};

    reset = 1'b0;
    start_i = 1'b0;
    set_in(4'b0, 32'h0, 32'h0, 5'd0);
    #12;
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk32("rst_data", alu_data_o, 32'h0);
    chk1("rst_zero", zero_o, 1'b1);
    chk1("rst_inv", invalid_op_o, 1'b0);
    last_data = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Back-to-back single-cycle operations straight from the table.
    for (int i = 0; i < 13; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
    tick();
    chk1("idle_done_low", done_o, 1'b0);

    run_shift("sll31", OP_SLL, 32'h00000001, 5'd31, 32'h80000000, -1);
    run_shift("srl4", OP_SRL, 32'h80000000, 5'd4, 32'h08000000, -1);
    run_shift("sll8_ign", OP_SLL, 32'h00000003, 5'd8, 32'h00000300, 3);
    run_shift("srl1_zero", OP_SRL, 32'h00000001, 5'd1, 32'h00000000, -1);

    // Reset asynchronously in the middle of a long SRL.
    set_in(OP_SRL, 32'h0, 32'hFFFFFFFF, 5'd20);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (6) tick();
    chk1("pre_rst_busy", busy_o, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("mid_rst_busy", busy_o, 1'b0);
    chk1("mid_rst_done", done_o, 1'b0);
    chk32("mid_rst_data", alu_data_o, 32'h0);
    chk1("mid_rst_zero", zero_o, 1'b1);
    chk1("mid_rst_inv", invalid_op_o, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done_o === 1'b1) done_cnt++;
      if (busy_o === 1'b1) busy_cnt++;
    end
    chk32("post_rst_no_done", 32'(done_cnt), 32'h0);
    chk32("post_rst_no_busy", 32'(busy_cnt), 32'h0);
    chk32("post_rst_data", alu_data_o, 32'h0);
    apply_vec('{OP_ADD, 32'h00000010, 32'h00000020, 5'd0, 32'h00000030, 1'b0, 1'b0}, "post_rst_add");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

endmodule
